// File: rtl/bp_cfg_pkg.sv
// Shared definitions for the per-core config bus endpoint: the register map,
// the request/response records and the cache-mode encoding.
package bp_cfg_pkg;

  localparam int unsigned bp_cfg_core_width_gp = 8;
  localparam int unsigned bp_cfg_addr_width_gp = 16;
  localparam int unsigned bp_cfg_data_width_gp = 64;
  localparam int unsigned bp_cfg_vaddr_width_gp = 39;

  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_freeze_gp      = 16'h0001;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_core_id_gp     = 16'h0002;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_icache_mode_gp = 16'h0003;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_dcache_mode_gp = 16'h0004;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_cce_mode_gp    = 16'h0005;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_err_cnt_gp     = 16'h0006;
  localparam logic [bp_cfg_addr_width_gp-1:0] bp_cfg_addr_npc_gp         = 16'h0010;

  // Error counter sticks here instead of wrapping.
  localparam logic [7:0] bp_cfg_err_max_gp = 8'hFF;

  typedef struct packed {
    logic                            w;
    logic [bp_cfg_core_width_gp-1:0] core;
    logic [bp_cfg_addr_width_gp-1:0] addr;
    logic [bp_cfg_data_width_gp-1:0] data;
  } bp_cfg_req_s;

  typedef struct packed {
    logic [bp_cfg_addr_width_gp-1:0] addr;
    logic [bp_cfg_data_width_gp-1:0] data;
  } bp_cfg_resp_s;

  typedef enum logic [1:0] {
    e_cache_mode_uncached = 2'd0,
    e_cache_mode_normal   = 2'd1,
    e_cache_mode_nonspec  = 2'd2
  } bp_cache_mode_e;

endpackage

// File: rtl/bp_cfg_responder_if.sv
// Config bus request channel plus read-response channel. Signal suffixes are
// from the responder's point of view.
interface bp_cfg_responder_if #(
  parameter int unsigned cfg_core_width_p = 8,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64
);

  logic                        cfg_v_i;
  logic                        cfg_w_i;
  logic [cfg_core_width_p-1:0] cfg_core_i;
  logic [cfg_addr_width_p-1:0] cfg_addr_i;
  logic [cfg_data_width_p-1:0] cfg_data_i;
  logic                        cfg_ready_o;
  logic                        resp_v_o;
  logic [cfg_addr_width_p-1:0] resp_addr_o;
  logic [cfg_data_width_p-1:0] resp_data_o;
  logic                        resp_ready_i;

  modport master (
    output cfg_v_i, cfg_w_i, cfg_core_i, cfg_addr_i, cfg_data_i, resp_ready_i,
    input  cfg_ready_o, resp_v_o, resp_addr_o, resp_data_o
  );

  modport slave (
    input  cfg_v_i, cfg_w_i, cfg_core_i, cfg_addr_i, cfg_data_i, resp_ready_i,
    output cfg_ready_o, resp_v_o, resp_addr_o, resp_data_o
  );

endinterface

// File: rtl/bp_cfg_reg_file.sv
// Per-core control registers: address decode, read mux, write update and the
// saturating error counter for unmapped accesses.
module bp_cfg_reg_file
  import bp_cfg_pkg::*;
#(
  parameter int unsigned cfg_core_width_p = 8,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter int unsigned vaddr_width_p    = 39
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] core_id_i,
  input  logic                        w_v_i,
  input  logic                        r_v_i,
  input  logic [cfg_addr_width_p-1:0] addr_i,
  input  logic [vaddr_width_p-1:0]    data_i,
  output logic [cfg_data_width_p-1:0] rdata_o,
  output logic                        freeze_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic                        npc_w_v_o
);

  logic                     r_freeze;
  logic [1:0]               r_icache_mode;
  logic [1:0]               r_dcache_mode;
  logic                     r_cce_mode;
  logic [7:0]               r_err_cnt;
  logic [vaddr_width_p-1:0] r_npc;
  logic                     r_npc_w_v;

  logic                     w_mapped;
  logic [7:0]               w_err_cnt_n;

  // Read mux; also flags addresses that fall outside the register map.
  always_comb begin
    rdata_o  = '0;
    w_mapped = 1'b1;
    case (addr_i)
      bp_cfg_addr_freeze_gp:      rdata_o[0] = r_freeze;
      bp_cfg_addr_core_id_gp:     rdata_o[cfg_core_width_p-1:0] = core_id_i;
      bp_cfg_addr_icache_mode_gp: rdata_o[1:0] = r_icache_mode;
      bp_cfg_addr_dcache_mode_gp: rdata_o[1:0] = r_dcache_mode;
      bp_cfg_addr_cce_mode_gp:    rdata_o[0] = r_cce_mode;
      bp_cfg_addr_err_cnt_gp:     rdata_o[7:0] = r_err_cnt;
      bp_cfg_addr_npc_gp:         rdata_o[vaddr_width_p-1:0] = r_npc;
      default:                    w_mapped = 1'b0;
    endcase
  end

  // Error counter: a write to it clears, any unmapped access bumps it up to the cap.
  always_comb begin
    w_err_cnt_n = r_err_cnt;
    if (w_v_i && (addr_i == bp_cfg_addr_err_cnt_gp)) begin
      w_err_cnt_n = '0;
    end else if ((w_v_i || r_v_i) && !w_mapped && (r_err_cnt != bp_cfg_err_max_gp)) begin
      w_err_cnt_n = r_err_cnt + 8'd1;
    end
  end

  // Register state; core_id writes fall through the empty arm and are ignored.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_freeze      <= 1'b1;
      r_icache_mode <= e_cache_mode_uncached;
      r_dcache_mode <= e_cache_mode_uncached;
      r_cce_mode    <= 1'b0;
      r_err_cnt     <= '0;
      r_npc         <= '0;
      r_npc_w_v     <= 1'b0;
    end else begin
      r_err_cnt <= w_err_cnt_n;
      r_npc_w_v <= 1'b0;
      if (w_v_i) begin
        case (addr_i)
          bp_cfg_addr_freeze_gp:      r_freeze      <= data_i[0];
          bp_cfg_addr_icache_mode_gp: r_icache_mode <= data_i[1:0];
          bp_cfg_addr_dcache_mode_gp: r_dcache_mode <= data_i[1:0];
          bp_cfg_addr_cce_mode_gp:    r_cce_mode    <= data_i[0];
          bp_cfg_addr_npc_gp: begin
            r_npc     <= data_i;
            r_npc_w_v <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign freeze_o      = r_freeze;
  assign icache_mode_o = r_icache_mode;
  assign dcache_mode_o = r_dcache_mode;
  assign cce_mode_o    = r_cce_mode;
  assign npc_o         = r_npc;
  assign npc_w_v_o     = r_npc_w_v;

endmodule

// File: rtl/bp_cfg_responder.sv
// Tile-side config bus endpoint. Filters requests addressed to this core,
// forwards them to the register file and returns read data one request at a time.
module bp_cfg_responder
  import bp_cfg_pkg::*;
#(
  parameter int unsigned cfg_core_width_p = 8,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter int unsigned vaddr_width_p    = 39
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] core_id_i,
  bp_cfg_responder_if.slave           cfg_if,
  output logic                        freeze_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic                        npc_w_v_o
);

  typedef enum logic [0:0] {e_ready, e_resp} state_e;

  state_e                      r_state;
  state_e                      w_state_n;
  bp_cfg_resp_s                r_resp;

  logic                        w_match;
  logic                        w_accept;
  logic                        w_wr_v;
  logic                        w_rd_v;
  logic                        w_cfg_ready;
  logic                        w_resp_v;
  logic [cfg_data_width_p-1:0] w_rdata;

  // Broadcast only applies to writes; a broadcast read is simply dropped.
  assign w_match  = (cfg_if.cfg_core_i == core_id_i)
                  || ((&cfg_if.cfg_core_i) && cfg_if.cfg_w_i);
  assign w_accept = cfg_if.cfg_v_i && (r_state == e_ready);
  assign w_wr_v   = w_accept && w_match && cfg_if.cfg_w_i;
  assign w_rd_v   = w_accept && w_match && !cfg_if.cfg_w_i;

  bp_cfg_reg_file #(
    .cfg_core_width_p(cfg_core_width_p),
    .cfg_addr_width_p(cfg_addr_width_p),
    .cfg_data_width_p(cfg_data_width_p),
    .vaddr_width_p   (vaddr_width_p)
  ) u_reg_file (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .core_id_i    (core_id_i),
    .w_v_i        (w_wr_v),
    .r_v_i        (w_rd_v),
    .addr_i       (cfg_if.cfg_addr_i),
    .data_i       (cfg_if.cfg_data_i[vaddr_width_p-1:0]),
    .rdata_o      (w_rdata),
    .freeze_o     (freeze_o),
    .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o),
    .cce_mode_o   (cce_mode_o),
    .npc_o        (npc_o),
    .npc_w_v_o    (npc_w_v_o)
  );

  // FSM state register; reset drops any pending response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_ready;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_n   = r_state;
    w_cfg_ready = 1'b0;
    w_resp_v    = 1'b0;
    unique case (r_state)
      e_ready: begin
        w_cfg_ready = 1'b1;
        if (w_rd_v) w_state_n = e_resp;
      end
      e_resp: begin
        w_resp_v = 1'b1;
        if (cfg_if.resp_ready_i) w_state_n = e_ready;
      end
      default: w_state_n = e_ready;
    endcase
  end

  // Snapshot the read at acceptance so it holds steady under backpressure.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_resp <= '0;
    end else if (w_rd_v) begin
      r_resp.addr <= cfg_if.cfg_addr_i;
      r_resp.data <= w_rdata;
    end
  end

  assign cfg_if.cfg_ready_o = w_cfg_ready;
  assign cfg_if.resp_v_o    = w_resp_v;
  assign cfg_if.resp_addr_o = r_resp.addr;
  assign cfg_if.resp_data_o = r_resp.data;

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Bench for bp_cfg_responder: directed scenarios with literal expectations,
// then random traffic checked every cycle against a register-map model.
module tb_bp_cfg_responder;
  import bp_cfg_pkg::*;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned VW = 39;
  localparam logic [7:0] CoreId = 8'h05;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze;
  logic [1:0]    icm;
  logic [1:0]    dcm;
  logic          cce;
  logic [VW-1:0] npc;
  logic          npc_wv;

  int n_checks = 0;
  int n_pass   = 0;

  bp_cfg_responder_if #(
    .cfg_core_width_p(CW), .cfg_addr_width_p(AW), .cfg_data_width_p(DW)
  ) cfg_if ();

  bp_cfg_responder #(
    .cfg_core_width_p(CW), .cfg_addr_width_p(AW),
    .cfg_data_width_p(DW), .vaddr_width_p(VW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .core_id_i    (CoreId),
    .cfg_if       (cfg_if),
    .freeze_o     (freeze),
    .icache_mode_o(icm),
    .dcache_mode_o(dcm),
    .cce_mode_o   (cce),
    .npc_o        (npc),
    .npc_w_v_o    (npc_wv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic          m_freeze  = 1'b1;
  logic [1:0]    m_icm     = '0;
  logic [1:0]    m_dcm     = '0;
  logic          m_cce     = 1'b0;
  logic [7:0]    m_err     = '0;
  logic [VW-1:0] m_npc     = '0;
  logic          m_npc_pl  = 1'b0;
  logic          m_pending = 1'b0;
  logic [15:0]   m_raddr   = '0;
  logic [63:0]   m_rdata   = '0;

  function automatic logic m_mapped(input logic [15:0] a);
    return a inside {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0010};
  endfunction

  function automatic logic [63:0] m_value(input logic [15:0] a);
    case (a)
      16'h0001: return 64'(m_freeze);
      16'h0002: return 64'(CoreId);
      16'h0003: return 64'(m_icm);
      16'h0004: return 64'(m_dcm);
      16'h0005: return 64'(m_cce);
      16'h0006: return 64'(m_err);
      16'h0010: return 64'(m_npc);
      default:  return 64'd0;
    endcase
  endfunction

  function automatic logic [7:0] m_bump(input logic [7:0] e);
    return (e == 8'd255) ? 8'd255 : e + 8'd1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_freeze <= 1'b1; m_icm <= '0; m_dcm <= '0; m_cce <= 1'b0;
      m_err <= '0; m_npc <= '0; m_npc_pl <= 1'b0; m_pending <= 1'b0;
    end else begin
      m_npc_pl <= 1'b0;
      if (m_pending) begin
        if (cfg_if.resp_ready_i) m_pending <= 1'b0;
      end else if (cfg_if.cfg_v_i &&
                   (cfg_if.cfg_core_i == CoreId ||
                    (cfg_if.cfg_core_i == 8'hFF && cfg_if.cfg_w_i))) begin
        if (cfg_if.cfg_w_i) begin
          case (cfg_if.cfg_addr_i)
            16'h0001: m_freeze <= cfg_if.cfg_data_i[0];
            16'h0002: ;
            16'h0003: m_icm <= cfg_if.cfg_data_i[1:0];
            16'h0004: m_dcm <= cfg_if.cfg_data_i[1:0];
            16'h0005: m_cce <= cfg_if.cfg_data_i[0];
            16'h0006: m_err <= '0;
            16'h0010: begin m_npc <= cfg_if.cfg_data_i[VW-1:0]; m_npc_pl <= 1'b1; end
            default:  m_err <= m_bump(m_err);
          endcase
        end else begin
          m_pending <= 1'b1;
          m_raddr   <= cfg_if.cfg_addr_i;
          m_rdata   <= m_value(cfg_if.cfg_addr_i);
          if (!m_mapped(cfg_if.cfg_addr_i)) m_err <= m_bump(m_err);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cfg_ready", 64'(cfg_if.cfg_ready_o), 64'(!m_pending));
    check("resp_v", 64'(cfg_if.resp_v_o), 64'(m_pending));
    check("freeze", 64'(freeze), 64'(m_freeze));
    check("icache_mode", 64'(icm), 64'(m_icm));
    check("dcache_mode", 64'(dcm), 64'(m_dcm));
    check("cce_mode", 64'(cce), 64'(m_cce));
    check("npc", 64'(npc), 64'(m_npc));
    check("npc_w_v", 64'(npc_wv), 64'(m_npc_pl));
    if (m_pending) begin
      check("resp_addr", 64'(cfg_if.resp_addr_o), 64'(m_raddr));
      check("resp_data", cfg_if.resp_data_o, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic w, input logic [7:0] core, input logic [15:0] addr,
                      input logic [63:0] data);
    int n;
    n = 0;
    cfg_if.cfg_v_i    = 1'b1;
    cfg_if.cfg_w_i    = w;
    cfg_if.cfg_core_i = core;
    cfg_if.cfg_addr_i = addr;
    cfg_if.cfg_data_i = data;
    @(negedge clk);
    while (!cfg_if.cfg_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_if.cfg_ready_o) check("accept_timeout", 64'(cfg_if.cfg_ready_o), 64'd1);
    @(posedge clk);
    #1;
    cfg_if.cfg_v_i = 1'b0;
  endtask

  task automatic read_lit(input logic [15:0] addr, input logic [63:0] exp, input string name);
    cfg_if.resp_ready_i = 1'b0;
    send(1'b0, CoreId, addr, 64'd0);
    check({name, "_v"}, 64'(cfg_if.resp_v_o), 64'd1);
    check({name, "_addr"}, 64'(cfg_if.resp_addr_o), 64'(addr));
    check(name, cfg_if.resp_data_o, exp);
    cfg_if.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.resp_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  bp_cfg_req_s req;
  logic [15:0] addr_tbl [9];

  initial begin
    addr_tbl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                 16'h0006, 16'h0010, 16'h0777, 16'h0000};
    cfg_if.cfg_v_i = 1'b0; cfg_if.cfg_w_i = 1'b0; cfg_if.cfg_core_i = '0;
    cfg_if.cfg_addr_i = '0; cfg_if.cfg_data_i = '0; cfg_if.resp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. reset state
    check("rst_freeze", 64'(freeze), 64'd1);
    check("rst_icm", 64'(icm), 64'd0);
    check("rst_npc", 64'(npc), 64'd0);
    check("rst_ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    check("rst_resp_v", 64'(cfg_if.resp_v_o), 64'd0);

    // 2. npc write and one-cycle pulse
    send(1'b1, CoreId, 16'h0010, 64'h8000_0000);
    check("npc_lit", 64'(npc), 64'h8000_0000);
    check("npc_pulse_hi", 64'(npc_wv), 64'd1);
    @(posedge clk); #1;
    check("npc_pulse_lo", 64'(npc_wv), 64'd0);

    // 3. held response under backpressure; a request during RESP is not taken
    send(1'b1, CoreId, 16'h0003, 64'd2);
    send(1'b0, CoreId, 16'h0003, 64'd0);
    cfg_if.cfg_v_i = 1'b1; cfg_if.cfg_w_i = 1'b1; cfg_if.cfg_core_i = CoreId;
    cfg_if.cfg_addr_i = 16'h0003; cfg_if.cfg_data_i = 64'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_v", 64'(cfg_if.resp_v_o), 64'd1);
      check("hold_data", cfg_if.resp_data_o, 64'd2);
      check("hold_ready", 64'(cfg_if.cfg_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    cfg_if.cfg_v_i = 1'b0;
    cfg_if.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    cfg_if.resp_ready_i = 1'b0;
    check("release_v", 64'(cfg_if.resp_v_o), 64'd0);
    check("release_ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    check("icm_unchanged", 64'(icm), 64'd2);

    // 4. broadcast write, foreign-core write, broadcast read
    send(1'b1, 8'hFF, 16'h0001, 64'd0);
    check("bcast_freeze", 64'(freeze), 64'd0);
    send(1'b1, CoreId + 8'd1, 16'h0001, 64'd1);
    check("other_core_freeze", 64'(freeze), 64'd0);
    send(1'b0, 8'hFF, 16'h0006, 64'd0);
    check("bcast_read_dropped", 64'(cfg_if.resp_v_o), 64'd0);

    // 5. error counter saturation and clear
    for (int i = 0; i < 260; i++) send(1'b1, CoreId, 16'h0777, 64'(i));
    read_lit(16'h0006, 64'd255, "err_sat");
    read_lit(16'h0777, 64'd0, "unmapped_rd");
    send(1'b1, CoreId, 16'h0006, 64'hDEAD);
    read_lit(16'h0006, 64'd0, "err_clr");
    read_lit(16'h0002, 64'(CoreId), "core_id_rd");

    // 6. reset while a response is pending
    cfg_if.resp_ready_i = 1'b0;
    send(1'b0, CoreId, 16'h0003, 64'd0);
    check("pre_rst_v", 64'(cfg_if.resp_v_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_v", 64'(cfg_if.resp_v_o), 64'd0);
    check("rst_async_freeze", 64'(freeze), 64'd1);
    check("rst_async_icm", 64'(icm), 64'd0);
    check("rst_async_npc", 64'(npc), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale_resp", 64'(cfg_if.resp_v_o), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req.w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       req.core = CoreId;
        1:       req.core = CoreId + 8'd1;
        default: req.core = 8'hFF;
      endcase
      req.addr = addr_tbl[$urandom_range(0, 8)];
      if (req.addr == 16'h0000) req.addr = 16'($urandom);
      req.data = {$urandom, $urandom};
      cfg_if.cfg_v_i      = ($urandom_range(0, 3) != 0);
      cfg_if.cfg_w_i      = req.w;
      cfg_if.cfg_core_i   = req.core;
      cfg_if.cfg_addr_i   = req.addr;
      cfg_if.cfg_data_i   = req.data;
      cfg_if.resp_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    cfg_if.cfg_v_i = 1'b0;
    cfg_if.resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
